floor_request_latch: RTL and testbench
======================================

// Module: floor_request_latch
// PURPOSE
//  Downstream consumer of the per-key debouncers: takes FLOORS debounced key levels, detects
//  press edges and latches one pending request per floor. Keeps pending floors in age order
//  (oldest at head) for the elevator controller. The controller retires a floor on arrival.
// PARAMETERS
//  FLOORS  4                    number of floor keys / request slots (2..16)
//  FW      $clog2(FLOORS)       floor index width (derived localparam, not overridable)
// PORTS
//  clk         in   1       system clock, all state on rising edge
//  rst_n       in   1       asynchronous active-low reset
//  key_lvl     in   FLOORS  debounced key levels, 1 = pressed, bit i = floor i
//  clr_valid   in   1       controller retires a floor this cycle
//  clr_floor   in   FW      floor index to retire, qualified by clr_valid
//  pending     out  FLOORS  bitmap of latched requests
//  count       out  FW+1    number of pending requests, 0..FLOORS
//  head_valid  out  1       queue non-empty (count != 0)
//  head_floor  out  FW      oldest pending floor, 0 when head_valid = 0
//  new_req     out  1       one-cycle pulse: at least one request enqueued on this edge
// BEHAVIOUR
//  - Reset (async assert, sync release): pending=0, count=0, head_valid=0, head_floor=0,
//    new_req=0, queue cleared, key_prev=all-ones (a key held through reset is not a press;
//    it must be released and pressed again).
//  - Edge detect: rise[i] = key_lvl[i] & ~key_prev[i]; key_prev <= key_lvl every cycle.
//  - All outputs registered; a rise sampled at edge k is visible on pending/count/head at k.
//  - Queue: FLOORS entries of FW bits, entry 0 = head. Each floor appears at most once, so
//    overflow is impossible; count never exceeds FLOORS.
//  - Enqueue: rise on non-pending floor appends at tail. Several rises on one edge append in
//    ascending floor index (lowest index = oldest). new_req = 1 if any append occurs.
//  - Rise on already-pending floor: ignored (no reorder, no new_req).
//  - Retire: clr_valid with clr_floor pending removes it; younger entries shift one slot
//    toward head (order preserved). clr_floor not pending or >= FLOORS: no-op.
//  - Same edge, clear and rise on same floor: clear wins, rise is dropped, no new_req.
//  - Same edge, clear on floor A and rises on others: removal first, then appends.
//  - Removal of the last entry: head_valid falls, head_floor returns to 0 on the same edge.
//  - Reset mid-operation: queue discarded immediately, no pulse generated on release.
// CONFIGURATION
//  REQ_CANCEL_EN defined: rise on an already-pending floor cancels it (removed exactly as a
//    retire, no new_req). If also retired by clr_valid on that edge, it is removed once.
//  REQ_CANCEL_EN undefined: rise on a pending floor is ignored as above.
// TESTING (FLOORS=4)
//  1 Hold key_lvl=4'b0010 through reset release -> pending stays 0, new_req never pulses;
//    release then press floor 1 -> pending=0010, count=1, head_floor=1, new_req one cycle.
//  2 Press 2, then 0, then 3 on separate edges -> count=3, head_floor=2; clr floor 2 ->
//    head_floor=0, count=2; clr 0 -> head_floor=3; clr 3 -> head_valid=0, head_floor=0.
//  3 Same-edge rises key_lvl 0000->1010 -> queue order 1,3, head_floor=1, single new_req pulse.
//  4 Floor 2 pending, clr_valid=1 clr_floor=2 plus rise on floor 2 same edge -> pending=0000,
//    new_req=0; clr_floor=3 when 3 not pending -> no state change.
//  5 Queue 0,1,2,3 full (count=4), clear floor 1 -> order 0,2,3, count=3; re-press 1 -> tail.
//  6 REQ_CANCEL_EN: floor 3 pending, re-press 3 -> pending bit 3 clears, count-1, new_req=0;
//    without macro -> unchanged. Assert rst_n mid-queue -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/floor_request_latch_if.sv
// Request-latch bus: key levels and retire command in, pending queue status out.
// The master modport is the driving side (bench or debouncer/controller glue), slave is the latch.
interface floor_request_latch_if #(
  parameter int FLOORS = 4
);
  localparam int FW = $clog2(FLOORS);

  logic [FLOORS-1:0] key_lvl;
  logic              clr_valid;
  logic [FW-1:0]     clr_floor;
  logic [FLOORS-1:0] pending;
  logic [FW:0]       count;
  logic              head_valid;
  logic [FW-1:0]     head_floor;
  logic              new_req;

  modport master (
    output key_lvl, clr_valid, clr_floor,
    input  pending, count, head_valid, head_floor, new_req
  );

  modport slave (
    input  key_lvl, clr_valid, clr_floor,
    output pending, count, head_valid, head_floor, new_req
  );
endinterface

// File: rtl/floor_request_latch.sv
// Latches one request per floor from debounced key press edges and keeps them in age order.
// Optional feature macro REQ_CANCEL_EN: re-pressing a pending floor cancels its request.
module floor_request_latch #(
  parameter int FLOORS = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  floor_request_latch_if.slave         bus
);
  localparam int FW = $clog2(FLOORS);

  logic [FLOORS-1:0] key_prev;
  logic [FW-1:0]     q_r [FLOORS];
  logic [FW-1:0]     q_n [FLOORS];
  logic [FW:0]       cnt_r;
  logic [FW:0]       cnt_n;
  logic [FLOORS-1:0] pend_r;
  logic [FLOORS-1:0] pend_n;
  logic              new_req_r;
  logic              new_req_n;
  logic              head_valid_r;
  logic [FW-1:0]     head_floor_r;

  logic [FLOORS-1:0] rise;
  logic [FLOORS-1:0] clr_mask;
  logic [FLOORS-1:0] cancel;
  logic [FLOORS-1:0] rm;
  logic [FLOORS-1:0] add;
  logic [FW:0]       wr;

  // An out-of-range clr_floor matches no bit, so it naturally becomes a no-op.
  always_comb begin
    rise     = bus.key_lvl & ~key_prev;
    clr_mask = '0;
    for (int i = 0; i < FLOORS; i++) begin
      clr_mask[i] = bus.clr_valid && (bus.clr_floor == FW'(i));
    end
`ifdef REQ_CANCEL_EN
    cancel = rise & pend_r;
`else
    cancel = '0;
`endif
    rm  = pend_r & (clr_mask | cancel);
    add = rise & ~pend_r & ~clr_mask;

    for (int j = 0; j < FLOORS; j++) begin
      q_n[j] = '0;
    end
    wr = '0;
    // Compact survivors toward the head, then append new rises oldest-first by index.
    for (int j = 0; j < FLOORS; j++) begin
      if (((FW+1)'(j) < cnt_r) && !rm[q_r[j]]) begin
        q_n[wr[FW-1:0]] = q_r[j];
        wr = wr + (FW+1)'(1);
      end
    end
    for (int i = 0; i < FLOORS; i++) begin
      if (add[i]) begin
        q_n[wr[FW-1:0]] = FW'(i);
        wr = wr + (FW+1)'(1);
      end
    end
    cnt_n     = wr;
    pend_n    = (pend_r & ~rm) | add;
    new_req_n = |add;
  end

  // key_prev resets to all-ones so a key held through reset never counts as a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_prev     <= '1;
      cnt_r        <= '0;
      pend_r       <= '0;
      new_req_r    <= 1'b0;
      head_valid_r <= 1'b0;
      head_floor_r <= '0;
      for (int j = 0; j < FLOORS; j++) begin
        q_r[j] <= '0;
      end
    end else begin
      key_prev     <= bus.key_lvl;
      cnt_r        <= cnt_n;
      pend_r       <= pend_n;
      new_req_r    <= new_req_n;
      head_valid_r <= (cnt_n != '0);
      head_floor_r <= q_n[0];
      for (int j = 0; j < FLOORS; j++) begin
        q_r[j] <= q_n[j];
      end
    end
  end

  assign bus.pending    = pend_r;
  assign bus.count      = cnt_r;
  assign bus.head_valid = head_valid_r;
  assign bus.head_floor = head_floor_r;
  assign bus.new_req    = new_req_r;
endmodule

// File: tb/tb_floor_request_latch.sv
// Self-checking bench for floor_request_latch (FLOORS=4) against a queue-based reference model.
module tb_floor_request_latch;
  localparam int FLOORS = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  floor_request_latch_if #(.FLOORS(FLOORS)) bus ();
  floor_request_latch #(.FLOORS(FLOORS)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int total = 0;
  int bad = 0;

  // Reference model: a plain age-ordered list of floor numbers.
  int         mq[$];
  logic [3:0] m_prev;
  logic       m_new;

  function automatic logic [3:0] m_pending();
    logic [3:0] r;
    r = '0;
    foreach (mq[k]) r[mq[k]] = 1'b1;
    return r;
  endfunction

  function automatic int m_head();
    return (mq.size() != 0) ? mq[0] : 0;
  endfunction

  task automatic step(input logic [3:0] key, input logic cv, input logic [1:0] cf);
    logic [3:0] rise;
    logic [3:0] pend0;
    bit drop;
    pend0  = m_pending();
    rise   = key & ~m_prev;
    m_prev = key;
    m_new  = 1'b0;
    for (int k = mq.size() - 1; k >= 0; k--) begin
      drop = cv && (int'(cf) == mq[k]);
`ifdef REQ_CANCEL_EN
      if (rise[mq[k]]) drop = 1'b1;
`endif
      if (drop) mq.delete(k);
    end
    for (int i = 0; i < 4; i++) begin
      if (rise[i] && !pend0[i] && !(cv && int'(cf) == i)) begin
        mq.push_back(i);
        m_new = 1'b1;
      end
    end
    bus.key_lvl   = key;
    bus.clr_valid = cv;
    bus.clr_floor = cf;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int n = 0; n < FLOORS + 1 && mq.size() != 0; n++) begin
      step(4'b0000, 1'b1, 2'(mq[0]));
    end
    step(4'b0000, 1'b0, 2'd0);
    total++;
    if (bus.count !== 3'd0) begin
      bad++;
      $display("[TB] FAIL drain count got=%0d want=0", bus.count);
    end
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.key_lvl   = 4'b0010;
    bus.clr_valid = 1'b0;
    bus.clr_floor = '0;
    m_prev        = 4'b1111;
    mq.delete();
    repeat (3) @(posedge clk);
    #2;
    total++;
    if ({bus.pending, bus.count, bus.head_valid, bus.head_floor, bus.new_req} !== '0) begin
      bad++;
      $display("[TB] FAIL reset_outputs got=%b want=0",
               {bus.pending, bus.count, bus.head_valid, bus.head_floor, bus.new_req});
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int n = 0; n < 3; n++) begin
      step(4'b0010, 1'b0, 2'd0);
      total++;
      if (bus.pending !== 4'b0000 || bus.new_req !== 1'b0) begin
        bad++;
        $display("[TB] FAIL held_key pending=%b new_req=%b want 0000/0", bus.pending, bus.new_req);
      end
    end
    step(4'b0000, 1'b0, 2'd0);
    step(4'b0010, 1'b0, 2'd0);
    total++;
    if (bus.pending !== 4'b0010 || bus.count !== 3'd1 || bus.head_floor !== 2'd1 ||
        bus.head_valid !== 1'b1 || bus.new_req !== 1'b1) begin
      bad++;
      $display("[TB] FAIL first_press pend=%b cnt=%0d head=%0d hv=%b nr=%b want 0010/1/1/1/1",
               bus.pending, bus.count, bus.head_floor, bus.head_valid, bus.new_req);
    end
    step(4'b0010, 1'b0, 2'd0);
    total++;
    if (bus.new_req !== 1'b0) begin
      bad++;
      $display("[TB] FAIL pulse_width new_req got=%b want=0", bus.new_req);
    end
    drain();
  endtask

  task automatic test_order_retire();
    step(4'b0100, 1'b0, 2'd0);
    step(4'b0101, 1'b0, 2'd0);
    step(4'b1101, 1'b0, 2'd0);
    total++;
    if (bus.count !== 3'd3 || bus.head_floor !== 2'd2) begin
      bad++;
      $display("[TB] FAIL order_fill cnt=%0d head=%0d want 3/2", bus.count, bus.head_floor);
    end
    step(4'b0000, 1'b1, 2'd2);
    total++;
    if (bus.count !== 3'd2 || bus.head_floor !== 2'd0) begin
      bad++;
      $display("[TB] FAIL retire_2 cnt=%0d head=%0d want 2/0", bus.count, bus.head_floor);
    end
    step(4'b0000, 1'b1, 2'd0);
    total++;
    if (bus.head_floor !== 2'd3 || bus.pending !== 4'b1000) begin
      bad++;
      $display("[TB] FAIL retire_0 head=%0d pend=%b want 3/1000", bus.head_floor, bus.pending);
    end
    step(4'b0000, 1'b1, 2'd3);
    total++;
    if (bus.head_valid !== 1'b0 || bus.head_floor !== 2'd0 || bus.count !== 3'd0) begin
      bad++;
      $display("[TB] FAIL retire_last hv=%b head=%0d cnt=%0d want 0/0/0",
               bus.head_valid, bus.head_floor, bus.count);
    end
  endtask

  task automatic test_same_edge();
    int nr_pulses;
    step(4'b1010, 1'b0, 2'd0);
    nr_pulses = int'(bus.new_req);
    total++;
    if (bus.head_floor !== 2'd1 || bus.count !== 3'd2 || bus.pending !== 4'b1010) begin
      bad++;
      $display("[TB] FAIL same_edge head=%0d cnt=%0d pend=%b want 1/2/1010",
               bus.head_floor, bus.count, bus.pending);
    end
    step(4'b1010, 1'b1, 2'd1);
    nr_pulses += int'(bus.new_req);
    total++;
    if (nr_pulses !== 1 || bus.head_floor !== 2'd3) begin
      bad++;
      $display("[TB] FAIL same_edge_order pulses=%0d head=%0d want 1/3", nr_pulses, bus.head_floor);
    end
    drain();
  endtask

  task automatic test_clear_vs_rise();
    step(4'b0100, 1'b0, 2'd0);
    step(4'b0000, 1'b0, 2'd0);
    step(4'b0100, 1'b1, 2'd2);
    total++;
    if (bus.pending !== 4'b0000 || bus.new_req !== 1'b0 || bus.count !== 3'd0) begin
      bad++;
      $display("[TB] FAIL clear_wins pend=%b nr=%b cnt=%0d want 0000/0/0",
               bus.pending, bus.new_req, bus.count);
    end
    step(4'b0000, 1'b0, 2'd0);
    step(4'b0001, 1'b0, 2'd0);
    step(4'b0001, 1'b1, 2'd3);
    total++;
    if (bus.pending !== 4'b0001 || bus.count !== 3'd1 || bus.head_floor !== 2'd0) begin
      bad++;
      $display("[TB] FAIL clr_not_pending pend=%b cnt=%0d head=%0d want 0001/1/0",
               bus.pending, bus.count, bus.head_floor);
    end
    drain();
  endtask

  task automatic test_full_queue();
    logic [1:0] want_heads [4];
    want_heads = '{2'd2, 2'd3, 2'd1, 2'd0};
    step(4'b0001, 1'b0, 2'd0);
    step(4'b0011, 1'b0, 2'd0);
    step(4'b0111, 1'b0, 2'd0);
    step(4'b1111, 1'b0, 2'd0);
    total++;
    if (bus.count !== 3'd4 || bus.pending !== 4'b1111) begin
      bad++;
      $display("[TB] FAIL full cnt=%0d pend=%b want 4/1111", bus.count, bus.pending);
    end
    step(4'b1111, 1'b1, 2'd1);
    total++;
    if (bus.count !== 3'd3 || bus.head_floor !== 2'd0 || bus.pending !== 4'b1101) begin
      bad++;
      $display("[TB] FAIL full_clr1 cnt=%0d head=%0d pend=%b want 3/0/1101",
               bus.count, bus.head_floor, bus.pending);
    end
    step(4'b1101, 1'b0, 2'd0);
    step(4'b1111, 1'b0, 2'd0);
    total++;
    if (bus.count !== 3'd4 || bus.new_req !== 1'b1) begin
      bad++;
      $display("[TB] FAIL repress_1 cnt=%0d nr=%b want 4/1", bus.count, bus.new_req);
    end
    // Queue should now be 0,2,3,1; retiring the head reveals each successor.
    for (int n = 0; n < 4; n++) begin
      step(4'b1111, 1'b1, bus.head_floor);
      total++;
      if (bus.head_floor !== want_heads[n]) begin
        bad++;
        $display("[TB] FAIL full_order[%0d] head=%0d want=%0d", n, bus.head_floor, want_heads[n]);
      end
    end
    drain();
  endtask

  task automatic test_cancel();
    step(4'b1000, 1'b0, 2'd0);
    step(4'b0000, 1'b0, 2'd0);
    step(4'b1000, 1'b0, 2'd0);
    total++;
`ifdef REQ_CANCEL_EN
    if (bus.pending !== 4'b0000 || bus.count !== 3'd0 || bus.new_req !== 1'b0) begin
      bad++;
      $display("[TB] FAIL cancel pend=%b cnt=%0d nr=%b want 0000/0/0",
               bus.pending, bus.count, bus.new_req);
    end
`else
    if (bus.pending !== 4'b1000 || bus.count !== 3'd1 || bus.new_req !== 1'b0) begin
      bad++;
      $display("[TB] FAIL repress_ignored pend=%b cnt=%0d nr=%b want 1000/1/0",
               bus.pending, bus.count, bus.new_req);
    end
`endif
    drain();
  endtask

  task automatic test_random();
    logic [3:0] key;
    logic cv;
    logic [1:0] cf;
    key = 4'b0000;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 2) == 0) key[$urandom_range(0, 3)] = ~key[$urandom_range(0, 3)];
      if ($urandom_range(0, 3) == 0) key = 4'($urandom);
      cv = ($urandom_range(0, 2) == 0);
      cf = 2'($urandom);
      step(key, cv, cf);
      total++;
      if (bus.pending !== m_pending() || bus.count !== 3'(mq.size()) ||
          bus.head_valid !== (mq.size() != 0) || bus.head_floor !== 2'(m_head()) ||
          bus.new_req !== m_new) begin
        bad++;
        $display("[TB] FAIL random[%0d] got pend=%b cnt=%0d hv=%b head=%0d nr=%b want %b/%0d/%b/%0d/%b",
                 n, bus.pending, bus.count, bus.head_valid, bus.head_floor, bus.new_req,
                 m_pending(), mq.size(), (mq.size() != 0), m_head(), m_new);
      end
    end
    drain();
  endtask

  task automatic test_async_reset();
    step(4'b0001, 1'b0, 2'd0);
    step(4'b0011, 1'b0, 2'd0);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus.pending, bus.count, bus.head_valid, bus.head_floor, bus.new_req} !== '0) begin
      bad++;
      $display("[TB] FAIL async_reset got=%b want=0",
               {bus.pending, bus.count, bus.head_valid, bus.head_floor, bus.new_req});
    end
    mq.delete();
    m_prev = 4'b1111;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(4'b0011, 1'b0, 2'd0);
    total++;
    if (bus.new_req !== 1'b0 || bus.pending !== 4'b0000) begin
      bad++;
      $display("[TB] FAIL post_reset nr=%b pend=%b want 0/0000", bus.new_req, bus.pending);
    end
  endtask

  initial begin
    test_reset();
    test_order_retire();
    test_same_edge();
    test_clear_vs_rise();
    test_full_queue();
    test_cancel();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
